// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// forwarding select codes and the register specifier width.
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int LONG_CNT_W = 4;

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_LONG_BUSY  = 2'd2,
      HZ_FLUSH      = 2'd3
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// master: the datapath/decoder side; slave: the hazard controller.
interface pipeline_hazard_ctrl_if
   import pipeline_pkg::*;
   #(parameter int CNT_W = 32);

   logic [REG_ADDR_W-1:0] id_rs, id_rt;
   logic                  id_uses_rs, id_uses_rt;
   logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
   logic                  ex_reg_write, ex_mem_read, ex_long_op, ex_branch_taken;
   logic [REG_ADDR_W-1:0] mem_rd, wb_rd;
   logic                  mem_reg_write, wb_reg_write;

   logic                  pc_stall, ifid_stall, idex_hold, idex_bubble, ifid_flush;
   logic [1:0]            fwd_a, fwd_b, hz_state;
   logic [CNT_W-1:0]      stall_cnt, flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
             ex_reg_write, ex_mem_read, ex_long_op, ex_branch_taken,
             mem_rd, wb_rd, mem_reg_write, wb_reg_write,
      input  pc_stall, ifid_stall, idex_hold, idex_bubble, ifid_flush,
             fwd_a, fwd_b, hz_state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
             ex_reg_write, ex_mem_read, ex_long_op, ex_branch_taken,
             mem_rd, wb_rd, mem_reg_write, wb_reg_write,
      output pc_stall, ifid_stall, idex_hold, idex_bubble, ifid_flush,
             fwd_a, fwd_b, hz_state, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational ALU operand bypass select for one source specifier.
// MEM result beats WB result; register 0 is never bypassed.
module forward_unit
   import pipeline_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_src,
   input  logic [REG_ADDR_W-1:0] i_mem_rd,
   input  logic                  i_mem_reg_write,
   input  logic [REG_ADDR_W-1:0] i_wb_rd,
   input  logic                  i_wb_reg_write,
   output fwd_sel_t              o_sel
);

   // Pick the youngest in-flight producer of the source register.
   always_comb begin
      o_sel = FWD_REG;
      if (i_src != '0) begin
         if (i_mem_reg_write && (i_mem_rd == i_src))
            o_sel = FWD_MEM;
         else if (i_wb_reg_write && (i_wb_rd == i_src))
            o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, long-latency
// EX sequencing, taken-branch squash and operand forwarding selects.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int LONG_OP_LAT = 4,
   parameter int CNT_W       = 32
)(
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  bus
);

   // Counter preload: the RUN issue cycle plus LONG_OP_LAT-1 busy cycles.
   localparam logic [LONG_CNT_W-1:0] LONG_LOAD = LONG_CNT_W'(LONG_OP_LAT - 2);

   hz_state_t             r_state, w_state_nxt;
   logic [LONG_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic                  w_load_use;
   logic                  w_pc_stall, w_idex_hold, w_idex_bubble, w_ifid_flush;
   fwd_sel_t              w_fwd_a, w_fwd_b;

   assign w_load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                       ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                        (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

   forward_unit u_fwd_a (
      .i_src           (bus.ex_rs),
      .i_mem_rd        (bus.mem_rd),
      .i_mem_reg_write (bus.mem_reg_write),
      .i_wb_rd         (bus.wb_rd),
      .i_wb_reg_write  (bus.wb_reg_write),
      .o_sel           (w_fwd_a)
   );

   forward_unit u_fwd_b (
      .i_src           (bus.ex_rt),
      .i_mem_rd        (bus.mem_rd),
      .i_mem_reg_write (bus.mem_reg_write),
      .i_wb_rd         (bus.wb_rd),
      .i_wb_reg_write  (bus.wb_reg_write),
      .o_sel           (w_fwd_b)
   );

   // Hazard FSM state and long-op down-counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= HZ_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state and pipeline controls; branch beats long op beats load-use.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pc_stall    = 1'b0;
      w_idex_hold   = 1'b0;
      w_idex_bubble = 1'b0;
      w_ifid_flush  = 1'b0;
      case (r_state)
         HZ_RUN: begin
            if (bus.ex_branch_taken) begin
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
               w_state_nxt   = HZ_FLUSH;
            end else if (bus.ex_long_op) begin
               w_pc_stall  = 1'b1;
               w_idex_hold = 1'b1;
               w_cnt_nxt   = LONG_LOAD;
               w_state_nxt = HZ_LONG_BUSY;
            end else if (w_load_use) begin
               w_pc_stall    = 1'b1;
               w_idex_bubble = 1'b1;
               w_state_nxt   = HZ_LOAD_STALL;
            end
         end
         HZ_LOAD_STALL: w_state_nxt = HZ_RUN;
         HZ_LONG_BUSY: begin
            w_pc_stall  = 1'b1;
            w_idex_hold = 1'b1;
            if (r_cnt == '0)
               w_state_nxt = HZ_RUN;
            else
               w_cnt_nxt = r_cnt - 1'b1;
         end
         HZ_FLUSH: w_state_nxt = HZ_RUN;
         default: begin
            w_state_nxt = HZ_RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Controls are forced quiet while reset is held, independent of the clock.
   assign bus.pc_stall    = reset & w_pc_stall;
   assign bus.ifid_stall  = reset & w_pc_stall;
   assign bus.idex_hold   = reset & w_idex_hold;
   assign bus.idex_bubble = reset & w_idex_bubble;
   assign bus.ifid_flush  = reset & w_ifid_flush;
   assign bus.fwd_a       = reset ? w_fwd_a : FWD_REG;
   assign bus.fwd_b       = reset ? w_fwd_b : FWD_REG;
   assign bus.hz_state    = r_state;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   // Free-running stall/flush event counters, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_pc_stall)   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_ifid_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed steps followed by random
// traffic, every cycle compared against a cycle-budget reference model.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl
   import pipeline_pkg::*;
;
   localparam int LAT = 4;

   logic clk;
   logic reset;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();

   pipeline_hazard_ctrl #(.LONG_OP_LAT(LAT), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining frozen cycles and one-cycle follow-up flags.
   int   m_busy_left;
   bit   m_after_load, m_after_flush;
   int   m_stall_cnt, m_flush_cnt;
   logic e_pc, e_hold, e_bub, e_flush;
   logic [1:0] e_hz, e_fa, e_fb;

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (src == 0) return 2'b00;
      if (bus.mem_reg_write && bus.mem_rd == src) return 2'b10;
      if (bus.wb_reg_write && bus.wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit ref_load_use();
      return bus.ex_mem_read && bus.ex_rd != 0 &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
   endfunction

   task automatic model_eval();
      {e_pc, e_hold, e_bub, e_flush} = 4'b0000;
      e_hz = 2'd0; e_fa = 2'b00; e_fb = 2'b00;
      if (reset) begin
         e_fa = ref_fwd(bus.ex_rs);
         e_fb = ref_fwd(bus.ex_rt);
         if (m_busy_left > 0) begin
            e_hz = 2'd2; e_pc = 1'b1; e_hold = 1'b1;
         end else if (m_after_load) begin
            e_hz = 2'd1;
         end else if (m_after_flush) begin
            e_hz = 2'd3;
         end else if (bus.ex_branch_taken) begin
            e_flush = 1'b1; e_bub = 1'b1;
         end else if (bus.ex_long_op) begin
            e_pc = 1'b1; e_hold = 1'b1;
         end else if (ref_load_use()) begin
            e_pc = 1'b1; e_bub = 1'b1;
         end
      end
   endtask

   task automatic model_advance();
      if (!reset) begin
         m_busy_left = 0; m_after_load = 0; m_after_flush = 0;
         m_stall_cnt = 0; m_flush_cnt = 0;
         return;
      end
      if (e_pc)    m_stall_cnt++;
      if (e_flush) m_flush_cnt++;
      if (m_busy_left > 0)                   m_busy_left--;
      else if (m_after_load || m_after_flush) begin m_after_load = 0; m_after_flush = 0; end
      else if (bus.ex_branch_taken)           m_after_flush = 1;
      else if (bus.ex_long_op)                m_busy_left = LAT - 1;
      else if (ref_load_use())                m_after_load = 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs to the model, then clock once.
   task automatic step(input string tag);
      logic [31:0] exp_sc, exp_fc;
      #1;
      model_eval();
`ifdef HAZARD_PERF_CNT_EN
      exp_sc = 32'(m_stall_cnt); exp_fc = 32'(m_flush_cnt);
`else
      exp_sc = 32'd0; exp_fc = 32'd0;
`endif
      chk({tag, ".pc_stall"},    32'(bus.pc_stall),    32'(e_pc));
      chk({tag, ".ifid_stall"},  32'(bus.ifid_stall),  32'(e_pc));
      chk({tag, ".idex_hold"},   32'(bus.idex_hold),   32'(e_hold));
      chk({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'(e_bub));
      chk({tag, ".ifid_flush"},  32'(bus.ifid_flush),  32'(e_flush));
      chk({tag, ".fwd_a"},       32'(bus.fwd_a),       32'(e_fa));
      chk({tag, ".fwd_b"},       32'(bus.fwd_b),       32'(e_fb));
      chk({tag, ".hz_state"},    32'(bus.hz_state),    32'(e_hz));
      chk({tag, ".stall_cnt"},   bus.stall_cnt,        exp_sc);
      chk({tag, ".flush_cnt"},   bus.flush_cnt,        exp_fc);
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
      bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_rd = '0;
      bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_long_op = 0; bus.ex_branch_taken = 0;
      bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_reg_write = 0; bus.wb_reg_write = 0;
   endtask

   task automatic random_inputs();
      bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_uses_rs = 1'($urandom); bus.id_uses_rt = 1'($urandom);
      bus.ex_rs = 5'($urandom_range(0, 3)); bus.ex_rt = 5'($urandom_range(0, 3));
      bus.ex_rd = 5'($urandom_range(0, 3));
      bus.ex_reg_write = 1'($urandom); bus.ex_mem_read = ($urandom_range(0, 2) == 0);
      bus.ex_long_op = ($urandom_range(0, 7) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
      bus.mem_rd = 5'($urandom_range(0, 3)); bus.wb_rd = 5'($urandom_range(0, 3));
      bus.mem_reg_write = 1'($urandom); bus.wb_reg_write = 1'($urandom);
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      clear_inputs();
      bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = rd;
      bus.id_uses_rt = 1; bus.id_rt = 5'd9;
   endtask

   initial begin
      m_busy_left = 0; m_after_load = 0; m_after_flush = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
      clear_inputs();
      reset = 1'b0;
      #2;
      step("init");
      reset = 1'b1;

      // Forwarding: MEM wins over WB; register 0 never forwarded.
      bus.mem_reg_write = 1; bus.mem_rd = 5'd8; bus.ex_rs = 5'd8;
      bus.wb_reg_write = 1; bus.wb_rd = 5'd8;
      #1 chk("fwd_mem_pri", 32'(bus.fwd_a), 32'h2);
      step("fwd_mem");
      bus.mem_rd = '0; bus.ex_rs = '0; bus.wb_rd = '0;
      #1 chk("fwd_zero", 32'(bus.fwd_a), 32'h0);
      step("fwd_zero");

      // Load-use: one stall cycle, then LOAD_STALL, then RUN.
      set_load_use(5'd9);
      #1 chk("lu_stall", 32'({bus.pc_stall, bus.ifid_stall, bus.idex_bubble}), 32'h7);
      step("lu0");
      clear_inputs();
      #1 chk("lu_state1", 32'(bus.hz_state), 32'd1);
      step("lu1");
      #1 chk("lu_state0", 32'(bus.hz_state), 32'd0);
      step("lu2");
      set_load_use(5'd0);
      #1 chk("lu_rd0_nostall", 32'(bus.pc_stall), 32'd0);
      step("lu_rd0");

      // Long op: four frozen cycles, branch ignored while busy.
      clear_inputs();
      bus.ex_long_op = 1;
      for (int i = 0; i < LAT; i++) begin
         #1 chk("long_hold", 32'({bus.pc_stall, bus.idex_hold}), 32'h3);
         step("long");
         bus.ex_long_op = 0;
         bus.ex_branch_taken = (i == 0);
      end
      bus.ex_branch_taken = 0;
      #1 chk("long_done", 32'({bus.pc_stall, bus.hz_state}), 32'h0);
      step("long_done");

      // Branch beats long op and load-use in the same cycle.
      set_load_use(5'd9);
      bus.ex_long_op = 1; bus.ex_branch_taken = 1;
      #1 chk("br_pri", 32'({bus.ifid_flush, bus.idex_bubble, bus.pc_stall}), 32'h6);
      step("br");
      clear_inputs();
      #1 chk("br_flush_state", 32'(bus.hz_state), 32'd3);
      step("br_flush");
      #1 chk("br_run", 32'(bus.hz_state), 32'd0);
      step("br_run");

      // Asynchronous reset in the middle of a long op.
      bus.ex_long_op = 1;
      step("mid0");
      bus.ex_long_op = 0;
      step("mid1");
      random_inputs();
      reset = 1'b0;
      #1 chk("rst_async", 32'({bus.hz_state, bus.idex_hold, bus.pc_stall, bus.ifid_flush,
                                bus.idex_bubble, bus.fwd_a, bus.fwd_b}), 32'h0);
      step("rst_mid");
      reset = 1'b1;
      clear_inputs();
      bus.ex_long_op = 1;
      for (int i = 0; i < LAT; i++) begin
         #1 chk("long2_hold", 32'(bus.idex_hold), 32'd1);
         step("long2");
         bus.ex_long_op = 0;
      end
      #1 chk("long2_done", 32'(bus.idex_hold), 32'd0);
      step("long2_done");

      // Counter scenario: one load-use, one long op, two taken branches.
      reset = 1'b0;
      step("perf_rst");
      reset = 1'b1;
      set_load_use(5'd9); step("perf_lu");
      clear_inputs();     step("perf_lu1");
      bus.ex_long_op = 1;
      for (int i = 0; i < LAT; i++) begin step("perf_long"); bus.ex_long_op = 0; end
      bus.ex_branch_taken = 1; step("perf_br0");
      bus.ex_branch_taken = 0; step("perf_br0f");
      bus.ex_branch_taken = 1; step("perf_br1");
      bus.ex_branch_taken = 0; step("perf_br1f");
      #1;
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_cnt", bus.stall_cnt, 32'd5);
      chk("perf_flush_cnt", bus.flush_cnt, 32'd2);
`else
      chk("perf_stall_cnt", bus.stall_cnt, 32'd0);
      chk("perf_flush_cnt", bus.flush_cnt, 32'd0);
`endif

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         random_inputs();
         reset = ($urandom_range(0, 49) != 0);
         step("rand");
      end
      reset = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipelined datapath: the register file, ALU and pipeline registers are driven by this block's stall, bubble, flush and forward controls.
- Detects load-use hazards, sequences multi-cycle (long-latency) EX operations, and squashes the wrong path on a taken branch.
- Produces the ALU operand forwarding selects.
- Sits beside the main control decoder; it owns the hazard FSM.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- LONG_OP_LAT, 4, total EX cycles of a long op, including the issue cycle; legal range is 2..15.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_rs, id_rt  input  REG_ADDR_W  source specifiers of the instruction in ID.
- id_uses_rs, id_uses_rt  input  1  ID instruction actually reads rs/rt.
- ex_rs, ex_rt  input  REG_ADDR_W  source specifiers of the instruction in EX.
- ex_rd  input  REG_ADDR_W  destination of the instruction in EX.
- ex_reg_write, ex_mem_read  input  1  EX instruction writes a register / is a load.
- ex_long_op  input  1  EX instruction is long-latency (multiply/divide class).
- ex_branch_taken  input  1  branch resolved taken in EX.
- mem_rd, wb_rd  input  REG_ADDR_W  destinations in MEM/WB.
- mem_reg_write, wb_reg_write  input  1  write enables in MEM/WB.
- pc_stall  output  1  hold PC.
- ifid_stall  output  1  hold the IF/ID register.
- idex_hold  output  1  hold the ID/EX register (long op in progress).
- idex_bubble  output  1  load NOP into ID/EX.
- ifid_flush  output  1  load NOP into IF/ID.
- fwd_a, fwd_b  output  2  operand select: 00 regfile, 01 WB result, 10 MEM result.
- hz_state  output  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 LONG_BUSY, 3 FLUSH.
- stall_cnt, flush_cnt  output  CNT_W  performance counters (see Optional Feature).

Behaviour:
- FSM state and the long-op down-counter (4 bits) are registered.
- The outputs listed above are combinational from state, counter and inputs.
- On reset low, regardless of clk:
  - state is RUN and the counter is 0.
  - all stall/bubble/flush outputs are 0, fwd_a = fwd_b = 00, hz_state = 0, and both performance counters are 0.
- Register 0 never causes a hazard and is never forwarded.
- Forwarding, fwd_a (using ex_rs) and fwd_b (using ex_rt) alike:
  - 10 if mem_reg_write && mem_rd == src && src != 0.
  - else 01 if wb_reg_write && wb_rd == src && src != 0.
  - else 00.
  - MEM has priority over WB.
- Load-use condition: ex_mem_read && ex_rd != 0 && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd)).
- Priority within a cycle, evaluated in RUN: ex_branch_taken > ex_long_op > load-use.
- RUN, branch taken:
  - ifid_flush = 1 and idex_bubble = 1 in the same cycle; the PC is not stalled.
  - Next state is FLUSH. Any simultaneous load-use or long op in that cycle is ignored, because the wrong-path instructions are squashed.
- RUN, long op:
  - pc_stall, ifid_stall and idex_hold are 1.
  - The counter loads LONG_OP_LAT-2; next state is LONG_BUSY.
- RUN, load-use:
  - pc_stall = ifid_stall = 1 and idex_bubble = 1.
  - Next state is LOAD_STALL. The load-use latency is exactly one stall cycle.
- LOAD_STALL: no stall outputs are asserted; always returns to RUN. The forwarding path then supplies the load result via WB or MEM.
- LONG_BUSY:
  - pc_stall, ifid_stall and idex_hold stay 1; the counter decrements each cycle.
  - When the counter is 0, the controls are still held that cycle and the next state is RUN.
  - Net total: LONG_OP_LAT cycles with the front end frozen.
  - ex_branch_taken and ex_long_op inputs are ignored while in LONG_BUSY.
- FLUSH:
  - One cycle with no controls asserted, so the target fetch proceeds.
  - Next state is RUN.
  - hz_state = 3 is visible here for debug.
- Reset asserted mid-LONG_BUSY or mid-FLUSH: immediate return to RUN with counter 0 and all controls deasserted.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cnt increments by 1 on every cycle in which pc_stall == 1.
  - flush_cnt increments on every cycle in which ifid_flush == 1.
  - Both wrap modulo 2^CNT_W and are cleared only by reset.
- When undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared package pipeline_pkg holds:
  - the hz_state encodings (HZ_RUN, HZ_LOAD_STALL, HZ_LONG_BUSY, HZ_FLUSH);
  - the forwarding select encodings (FWD_REG, FWD_WB, FWD_MEM);
  - REG_ADDR_W.
- One sub-module, forward_unit, is natural: a purely combinational instance, used twice for fwd_a and fwd_b.
- The FSM and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Reset and bypass:
  - Stimulus: assert reset low mid-simulation with random inputs.
  - Required: all controls 0 and hz_state = 0 immediately, asynchronously.
  - Stimulus: mem_reg_write = 1, mem_rd = 8, ex_rs = 8, plus wb_reg_write = 1, wb_rd = 8.
  - Required: fwd_a = 10. With mem_rd = 0, ex_rs = 0: fwd_a = 00.
- Load-use:
  - Stimulus: ex_mem_read = 1, ex_rd = 9, id_uses_rt = 1, id_rt = 9.
  - Required: exactly one cycle of pc_stall = ifid_stall = idex_bubble = 1, then hz_state 1 -> 0.
  - Stimulus: same with ex_rd = 0.
  - Required: no stall.
- Long op:
  - Stimulus: ex_long_op pulse with LONG_OP_LAT = 4.
  - Required: pc_stall and idex_hold high for exactly 4 consecutive cycles, then RUN.
  - Stimulus: ex_branch_taken asserted during LONG_BUSY.
  - Required: ignored.
- Branch priority:
  - Stimulus: ex_branch_taken = 1 together with load-use and ex_long_op in the same cycle.
  - Required: ifid_flush = idex_bubble = 1, pc_stall = 0, next state FLUSH, then RUN.
- Reset mid-operation:
  - Stimulus: enter LONG_BUSY, then pulse reset low after 2 cycles.
  - Required: hz_state = 0, idex_hold = 0; a new long op afterwards stalls the full 4 cycles.
- HAZARD_PERF_CNT_EN defined:
  - Stimulus: one load-use, one LONG_OP_LAT = 4 long op, and two taken branches.
  - Required: stall_cnt = 5 and flush_cnt = 2.
  - Undefined: both counters read 0.
